// File: rtl/bram_tdp_if.sv
// One access port of the true-dual-port block RAM: request signals from the
// requester, read data and read-valid strobe back from the RAM.
interface bram_tdp_if #(
   parameter int DATA_W = 4,
   parameter int ADDR_W = 9
);
   logic              EN;
   logic              WE;
   logic [ADDR_W-1:0] ADDR;
   logic [DATA_W-1:0] WDATA;
   logic [DATA_W-1:0] RDATA;
   logic              RVALID;

   modport master (
      output EN, WE, ADDR, WDATA,
      input  RDATA, RVALID
   );

   modport slave (
      input  EN, WE, ADDR, WDATA,
      output RDATA, RVALID
   );
endinterface

// File: rtl/bram_tdp.sv
// Parametrised true-dual-port block RAM with per-port write mode, optional
// output register and read-valid strobes that follow the read latency.
module bram_tdp #(
   parameter int DATA_W     = 4,
   parameter int ADDR_W     = 9,
   parameter int OUT_REG    = 0,
   parameter int WRITE_MODE = 0
) (
   input  logic           CLK,
   input  logic           RST,
   bram_tdp_if.slave      A,
   bram_tdp_if.slave      B
);
   localparam int DEPTH = 2 ** ADDR_W;

   // Port 0 is A, port 1 is B, so both read pipelines share one generate body.
   logic [1:0]        en;
   logic [1:0]        we;
   logic [ADDR_W-1:0] addr  [2];
   logic [DATA_W-1:0] wdata [2];
   logic [DATA_W-1:0] rdata [2];
   logic [1:0]        rvalid;

   assign en[0]    = A.EN;
   assign we[0]    = A.WE;
   assign addr[0]  = A.ADDR;
   assign wdata[0] = A.WDATA;
   assign en[1]    = B.EN;
   assign we[1]    = B.WE;
   assign addr[1]  = B.ADDR;
   assign wdata[1] = B.WDATA;

   assign A.RDATA  = rdata[0];
   assign A.RVALID = rvalid[0];
   assign B.RDATA  = rdata[1];
   assign B.RVALID = rvalid[1];

   logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};
   logic              wr_a;
   logic              wr_b;

   // On a same-address double write port A wins and B's write is dropped.
   assign wr_a = en[0] && we[0] && !RST;
   assign wr_b = en[1] && we[1] && !RST && !(wr_a && (addr[0] == addr[1]));

   // NOTE: the array has no reset branch so it maps onto block RAM; RST only gates writes.
   always_ff @(posedge CLK) begin
      if (wr_a) mem_q[addr[0]] <= wdata[0];
      if (wr_b) mem_q[addr[1]] <= wdata[1];
   end

   for (genvar p = 0; p < 2; p++) begin : g_port
      logic [DATA_W-1:0] rd1_d;
      logic [DATA_W-1:0] rd1_q;
      logic              vld1_d;
      logic              vld1_q;

      // NOTE: hold value assigned first so a disabled port cannot infer a latch.
      always_comb begin
         rd1_d = rd1_q;
         if (en[p]) begin
            if (!we[p] || (WRITE_MODE == 0)) rd1_d = mem_q[addr[p]];
            else if (WRITE_MODE == 1)        rd1_d = wdata[p];
         end
      end

      assign vld1_d = en[p] && !(we[p] && (WRITE_MODE == 2));

      // NOTE: non-blocking updates give both ports the pre-edge memory word on a cross-port hit.
      always_ff @(posedge CLK or posedge RST) begin
         if (RST) begin
            rd1_q  <= '0;
            vld1_q <= 1'b0;
         end else begin
            rd1_q  <= rd1_d;
            vld1_q <= vld1_d;
         end
      end

      if (OUT_REG != 0) begin : g_oreg
         logic [DATA_W-1:0] rd2_q;
         logic              vld2_q;

         always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
               rd2_q  <= '0;
               vld2_q <= 1'b0;
            end else begin
               rd2_q  <= rd1_q;
               vld2_q <= vld1_q;
            end
         end

         assign rdata[p]  = rd2_q;
         assign rvalid[p] = vld2_q;
      end else begin : g_noreg
         assign rdata[p]  = rd1_q;
         assign rvalid[p] = vld1_q;
      end
   end
endmodule

// File: tb/tb_bram_tdp.sv
// Bench for bram_tdp: three latency-1 instances (write modes 0/1/2) plus one
// OUT_REG instance share the same stimulus and memory history.
module tb_bram_tdp;
   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NDUT = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          a_en = 1'b0, a_we = 1'b0, b_en = 1'b0, b_we = 1'b0;
   logic [AW-1:0] a_addr = '0, b_addr = '0;
   logic [DW-1:0] a_wd = '0, b_wd = '0;

   logic [NDUT-1:0][DW-1:0] a_rd_w, b_rd_w;
   logic [NDUT-1:0]         a_v_w, b_v_w;

   // Instance g: write mode g for g<3; instance 3 is OUT_REG=1, read-first.
   for (genvar g = 0; g < NDUT; g++) begin : g_dut
      bram_tdp_if #(.DATA_W(DW), .ADDR_W(AW)) a_if ();
      bram_tdp_if #(.DATA_W(DW), .ADDR_W(AW)) b_if ();

      assign a_if.EN = a_en;  assign a_if.WE = a_we;
      assign a_if.ADDR = a_addr;  assign a_if.WDATA = a_wd;
      assign b_if.EN = b_en;  assign b_if.WE = b_we;
      assign b_if.ADDR = b_addr;  assign b_if.WDATA = b_wd;
      assign a_rd_w[g] = a_if.RDATA;  assign a_v_w[g] = a_if.RVALID;
      assign b_rd_w[g] = b_if.RDATA;  assign b_v_w[g] = b_if.RVALID;

      bram_tdp #(
         .DATA_W(DW), .ADDR_W(AW),
         .OUT_REG((g == 3) ? 1 : 0),
         .WRITE_MODE((g == 3) ? 0 : g)
      ) dut (
         .CLK(clk), .RST(rst), .A(a_if.slave), .B(b_if.slave)
      );
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic          a_en, a_we;
      logic [AW-1:0] a_addr;
      logic [DW-1:0] a_wd;
      logic          b_en, b_we;
      logic [AW-1:0] b_addr;
      logic [DW-1:0] b_wd;
      logic [2:0][DW-1:0] a_rd;   // {mode2, mode1, mode0}
      logic [2:0]         a_v;
      logic [2:0][DW-1:0] b_rd;
      logic [2:0]         b_v;
   } vec_t;

   vec_t vecs [16];

   task automatic drive(input logic ae, input logic aw, input logic [AW-1:0] aa,
                        input logic [DW-1:0] ad, input logic be, input logic bw,
                        input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      a_en = ae; a_we = aw; a_addr = aa; a_wd = ad;
      b_en = be; b_we = bw; b_addr = ba; b_wd = bd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b1, 4'd3, 8'hA5, 1'b0, 1'b0, 4'd0, 8'h00, {8'h00, 8'hA5, 8'h00}, 3'b011, {8'h00, 8'h00, 8'h00}, 3'b000};
      vecs[1]  = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd3, 8'h00, {8'h00, 8'hA5, 8'h00}, 3'b000, {8'hA5, 8'hA5, 8'hA5}, 3'b111};
      vecs[2]  = '{1'b1, 1'b1, 4'd5, 8'h11, 1'b0, 1'b0, 4'd0, 8'h00, {8'h00, 8'h11, 8'h00}, 3'b011, {8'hA5, 8'hA5, 8'hA5}, 3'b000};
      vecs[3]  = '{1'b1, 1'b0, 4'd3, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, {8'hA5, 8'hA5, 8'hA5}, 3'b111, {8'hA5, 8'hA5, 8'hA5}, 3'b000};
      vecs[4]  = '{1'b1, 1'b1, 4'd5, 8'h22, 1'b0, 1'b0, 4'd0, 8'h00, {8'hA5, 8'h22, 8'h11}, 3'b011, {8'hA5, 8'hA5, 8'hA5}, 3'b000};
      vecs[5]  = '{1'b1, 1'b0, 4'd5, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, {8'h22, 8'h22, 8'h22}, 3'b111, {8'hA5, 8'hA5, 8'hA5}, 3'b000};
      vecs[6]  = '{1'b1, 1'b1, 4'd7, 8'h33, 1'b1, 1'b1, 4'd7, 8'h44, {8'h22, 8'h33, 8'h00}, 3'b011, {8'hA5, 8'h44, 8'h00}, 3'b011};
      vecs[7]  = '{1'b1, 1'b0, 4'd7, 8'h00, 1'b1, 1'b0, 4'd7, 8'h00, {8'h33, 8'h33, 8'h33}, 3'b111, {8'h33, 8'h33, 8'h33}, 3'b111};
      vecs[8]  = '{1'b1, 1'b1, 4'd9, 8'h66, 1'b0, 1'b0, 4'd0, 8'h00, {8'h33, 8'h66, 8'h00}, 3'b011, {8'h33, 8'h33, 8'h33}, 3'b000};
      vecs[9]  = '{1'b1, 1'b1, 4'd9, 8'h55, 1'b1, 1'b0, 4'd9, 8'h00, {8'h33, 8'h55, 8'h66}, 3'b011, {8'h66, 8'h66, 8'h66}, 3'b111};
      vecs[10] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b1, 1'b0, 4'd9, 8'h00, {8'h33, 8'h55, 8'h66}, 3'b000, {8'h55, 8'h55, 8'h55}, 3'b111};
      vecs[11] = '{1'b1, 1'b1, 4'd2, 8'h5A, 1'b0, 1'b0, 4'd0, 8'h00, {8'h33, 8'h5A, 8'h00}, 3'b011, {8'h55, 8'h55, 8'h55}, 3'b000};
      vecs[12] = '{1'b1, 1'b0, 4'd2, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, {8'h5A, 8'h5A, 8'h5A}, 3'b111, {8'h55, 8'h55, 8'h55}, 3'b000};
      for (int i = 13; i < 16; i++)
         vecs[i] = '{1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00, {8'h5A, 8'h5A, 8'h5A}, 3'b000, {8'h55, 8'h55, 8'h55}, 3'b000};

      // Reset state on every instance.
      tick();
      for (int g = 0; g < NDUT; g++) begin
         check($sformatf("reset a_rd d%0d", g), 32'(a_rd_w[g]), 32'h0);
         check($sformatf("reset a_v d%0d", g), 32'(a_v_w[g]), 32'h0);
         check($sformatf("reset b_rd d%0d", g), 32'(b_rd_w[g]), 32'h0);
         check($sformatf("reset b_v d%0d", g), 32'(b_v_w[g]), 32'h0);
      end
      rst = 1'b0;

      // Latency-1 instances, one vector per cycle.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].a_en, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wd,
               vecs[i].b_en, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wd);
         tick();
         for (int m = 0; m < 3; m++) begin
            check($sformatf("v%0d a_rd m%0d", i, m), 32'(a_rd_w[m]), 32'(vecs[i].a_rd[m]));
            check($sformatf("v%0d a_v m%0d", i, m), 32'(a_v_w[m]), 32'(vecs[i].a_v[m]));
            check($sformatf("v%0d b_rd m%0d", i, m), 32'(b_rd_w[m]), 32'(vecs[i].b_rd[m]));
            check($sformatf("v%0d b_v m%0d", i, m), 32'(b_v_w[m]), 32'(vecs[i].b_v[m]));
         end
      end

      // OUT_REG: fill addr 0..3, then stream four back-to-back reads.
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 1'b1, 4'(k), 8'(8'h10 + k), 1'b0, 1'b0, 4'd0, 8'h00);
         tick();
      end
      for (int k = 0; k < 6; k++) begin
         if (k < 4) drive(1'b1, 1'b0, 4'(k), 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
         else       drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
         tick();
         if (k >= 1 && k <= 4) begin
            check($sformatf("oreg stream rd %0d", k), 32'(a_rd_w[3]), 32'(8'h10 + k - 1));
            check($sformatf("oreg stream v %0d", k), 32'(a_v_w[3]), 32'h1);
         end else if (k == 5) begin
            check("oreg stream v end", 32'(a_v_w[3]), 32'h0);
         end
      end

      // OUT_REG: asynchronous reset with a read in flight, write blocked in reset.
      drive(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async rst oreg rd", 32'(a_rd_w[3]), 32'h0);
      check("async rst oreg v", 32'(a_v_w[3]), 32'h0);
      check("async rst lat1 rd", 32'(a_rd_w[0]), 32'h0);
      check("async rst lat1 v", 32'(a_v_w[0]), 32'h0);
      drive(1'b1, 1'b1, 4'd1, 8'hFF, 1'b0, 1'b0, 4'd0, 8'h00);
      tick();
      check("in rst oreg v", 32'(a_v_w[3]), 32'h0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      for (int k = 0; k < 2; k++) begin
         tick();
         check($sformatf("post rst oreg v %0d", k), 32'(a_v_w[3]), 32'h0);
         check($sformatf("post rst oreg rd %0d", k), 32'(a_rd_w[3]), 32'h0);
      end
      drive(1'b1, 1'b0, 4'd1, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      tick();
      check("rst write blocked rd", 32'(a_rd_w[0]), 32'h11);
      check("rst write blocked v", 32'(a_v_w[0]), 32'h1);
      drive(1'b0, 1'b0, 4'd0, 8'h00, 1'b0, 1'b0, 4'd0, 8'h00);
      tick();
      check("post rst oreg read rd", 32'(a_rd_w[3]), 32'h11);
      check("post rst oreg read v", 32'(a_v_w[3]), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
